// File: rtl/ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encodings,
// register-zero index, default sizing and the control-output bundle.
package ctrl_pkg;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT   = 2'd1;
  localparam logic [1:0] ST_FETCH_WAIT = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned MAX_WAIT_DEF = 64;

  // Bit order matches {pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_freeze}.
  typedef struct packed {
    logic pc_write;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_freeze;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF      = 5'b00000;
  localparam ctrl_t CTRL_GO       = 5'b10000;
  localparam ctrl_t CTRL_REDIRECT = 5'b10100;
  localparam ctrl_t CTRL_MEM_HOLD = 5'b01001;
  localparam ctrl_t CTRL_FETCH    = 5'b00100;
  localparam ctrl_t CTRL_LOAD_USE = 5'b01010;

  // True when the state encoding is one of the wait states.
  function automatic logic is_wait_state(input logic [1:0] st);
    return (st == ST_MEM_WAIT) || (st == ST_FETCH_WAIT);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds either source
// operand of the instruction in ID. Register zero never creates a hazard.
module hazard_detect
  import ctrl_pkg::*;
(
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use
);

  logic dest_live_s;
  logic src_match_s;

  assign dest_live_s = ex_memread && (ex_rt != REG_ZERO);
  assign src_match_s = (ex_rt == id_rs) || (ex_rt == id_rt);
  assign load_use    = dest_live_s && src_match_s;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// branch redirects, I/D-cache waits, stall-cycle counter and wait timeout.
module pipeline_hazard_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             icache_stall_i,
  input  logic             dcache_stall_i,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             timeout_o
);

  localparam int unsigned        WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]   STALL_MAX  = {CNT_W{1'b1}};

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              flush_pend_r;
  logic              flush_pend_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_nxt_s;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              timeout_r;
  logic              load_use_s;
  ctrl_t             run_ctrl_s;
  logic [1:0]        run_nxt_s;
  logic              run_set_pend_s;
  ctrl_t             dec_ctrl_s;
  ctrl_t             ctrl_s;

  hazard_detect u_hazard_detect (
    .ex_memread (ex_memread_i),
    .ex_rt      (ex_rt_i),
    .id_rs      (id_rs_i),
    .id_rt      (id_rt_i),
    .load_use   (load_use_s)
  );

  // RUN-state decision, also reused on the exit cycle out of MEM_WAIT.
  always_comb begin
    run_ctrl_s     = CTRL_GO;
    run_nxt_s      = ST_RUN;
    run_set_pend_s = 1'b0;
    if (dcache_stall_i) begin
      run_ctrl_s     = CTRL_MEM_HOLD;
      run_nxt_s      = ST_MEM_WAIT;
      run_set_pend_s = branch_taken_i;
    end else if (icache_stall_i) begin
      run_ctrl_s     = CTRL_FETCH;
      run_nxt_s      = ST_FETCH_WAIT;
      run_set_pend_s = branch_taken_i;
    end else if (load_use_s) begin
      run_ctrl_s     = CTRL_LOAD_USE;
    end else if (branch_taken_i) begin
      run_ctrl_s     = CTRL_REDIRECT;
    end else begin
      run_ctrl_s     = CTRL_GO;
    end
  end

  // Per-state output decode and next-state / pending-redirect selection.
  always_comb begin
    dec_ctrl_s       = CTRL_GO;
    state_nxt_s      = state_r;
    flush_pend_nxt_s = flush_pend_r;
    case (state_r)
      ST_RUN: begin
        dec_ctrl_s       = run_ctrl_s;
        state_nxt_s      = run_nxt_s;
        flush_pend_nxt_s = run_set_pend_s;
      end
      ST_MEM_WAIT: begin
        if (dcache_stall_i) begin
          dec_ctrl_s  = CTRL_MEM_HOLD;
          state_nxt_s = ST_MEM_WAIT;
        end else if (flush_pend_r) begin
          // The redirect held back during the D-cache wait wins the exit cycle.
          dec_ctrl_s       = CTRL_REDIRECT;
          state_nxt_s      = ST_RUN;
          flush_pend_nxt_s = 1'b0;
        end else begin
          dec_ctrl_s       = run_ctrl_s;
          state_nxt_s      = run_nxt_s;
          flush_pend_nxt_s = run_set_pend_s;
        end
      end
      ST_FETCH_WAIT: begin
        if (dcache_stall_i) begin
          dec_ctrl_s  = CTRL_MEM_HOLD;
          state_nxt_s = ST_FETCH_WAIT;
        end else if (icache_stall_i) begin
          dec_ctrl_s  = CTRL_FETCH;
          state_nxt_s = ST_FETCH_WAIT;
        end else if (flush_pend_r) begin
          dec_ctrl_s       = CTRL_REDIRECT;
          state_nxt_s      = ST_RUN;
          flush_pend_nxt_s = 1'b0;
        end else begin
          dec_ctrl_s       = CTRL_GO;
          state_nxt_s      = ST_RUN;
          flush_pend_nxt_s = 1'b0;
        end
      end
      default: begin
        dec_ctrl_s       = CTRL_OFF;
        state_nxt_s      = ST_RUN;
        flush_pend_nxt_s = 1'b0;
      end
    endcase
  end

  // Controls are forced low for as long as reset is held.
  always_comb begin
    if (!rst_n_i) begin
      ctrl_s = CTRL_OFF;
    end else begin
      ctrl_s = dec_ctrl_s;
    end
  end

  // Wait counter counts every cycle that ends in a wait state, saturating at the limit.
  always_comb begin
    if (is_wait_state(state_nxt_s)) begin
      if (wait_cnt_r == WAIT_LIMIT) begin
        wait_cnt_nxt_s = wait_cnt_r;
      end else begin
        wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
      end
    end else begin
      wait_cnt_nxt_s = {WAIT_W{1'b0}};
    end
  end

  // FSM state and pending-redirect flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r      <= ST_RUN;
      flush_pend_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      flush_pend_r <= flush_pend_nxt_s;
    end
  end

  // Consecutive wait-cycle counter and sticky timeout.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
      timeout_r  <= 1'b0;
    end else begin
      wait_cnt_r <= wait_cnt_nxt_s;
      if (wait_cnt_nxt_s == WAIT_LIMIT) begin
        timeout_r <= 1'b1;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (!ctrl_s.pc_write && (stall_cnt_r != STALL_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign pc_write_o    = ctrl_s.pc_write;
  assign ifid_stall_o  = ctrl_s.ifid_stall;
  assign ifid_flush_o  = ctrl_s.ifid_flush;
  assign idex_bubble_o = ctrl_s.idex_bubble;
  assign pipe_freeze_o = ctrl_s.pipe_freeze;
  assign stall_cnt_o   = stall_cnt_r;
  assign timeout_o     = timeout_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 64;
  localparam int STALL_SAT = 65535;

  // Expected control bundles {pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_freeze}
  localparam logic [4:0] E_OFF   = 5'b00000;
  localparam logic [4:0] E_GO    = 5'b10000;
  localparam logic [4:0] E_REDIR = 5'b10100;
  localparam logic [4:0] E_HOLD  = 5'b01001;
  localparam logic [4:0] E_FETCH = 5'b00100;
  localparam logic [4:0] E_LU    = 5'b01010;

  localparam int M_RUN = 0;
  localparam int M_MEM = 1;
  localparam int M_FETCH = 2;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [4:0]  id_rs_i = 5'd0;
  logic [4:0]  id_rt_i = 5'd0;
  logic        ex_memread_i = 1'b0;
  logic [4:0]  ex_rt_i = 5'd0;
  logic        branch_taken_i = 1'b0;
  logic        icache_stall_i = 1'b0;
  logic        dcache_stall_i = 1'b0;
  logic        pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o;
  logic [15:0] stall_cnt_o;
  logic        timeout_o;
  logic [4:0]  obs;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_mode = M_RUN;
  bit m_pend = 1'b0;
  int m_wait = 0;
  int m_stall = 0;
  bit m_to = 1'b0;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .ex_memread_i   (ex_memread_i),
    .ex_rt_i        (ex_rt_i),
    .branch_taken_i (branch_taken_i),
    .icache_stall_i (icache_stall_i),
    .dcache_stall_i (dcache_stall_i),
    .pc_write_o     (pc_write_o),
    .ifid_stall_o   (ifid_stall_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .pipe_freeze_o  (pipe_freeze_o),
    .stall_cnt_o    (stall_cnt_o),
    .timeout_o      (timeout_o)
  );

  assign obs = {pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Rules applied whenever the controller is running normally
  task automatic run_rules(input bit lu, input bit br, input bit ic, input bit dc,
                           output logic [4:0] exp, output int nmode, output bit npend);
    nmode = M_RUN;
    npend = 1'b0;
    if (dc) begin
      exp = E_HOLD; nmode = M_MEM; npend = br;
    end else if (ic) begin
      exp = E_FETCH; nmode = M_FETCH; npend = br;
    end else if (lu) begin
      exp = E_LU;
    end else if (br) begin
      exp = E_REDIR;
    end else begin
      exp = E_GO;
    end
  endtask

  // One clock of the reference model: returns expected controls and advances model state
  task automatic model_eval(output logic [4:0] exp, output int nmode, output bit npend);
    bit lu;
    lu = ex_memread_i && (ex_rt_i != 5'd0) && (ex_rt_i == id_rs_i || ex_rt_i == id_rt_i);
    nmode = m_mode;
    npend = m_pend;
    exp = E_GO;
    if (m_mode == M_RUN) begin
      run_rules(lu, branch_taken_i, icache_stall_i, dcache_stall_i, exp, nmode, npend);
    end else if (dcache_stall_i) begin
      exp = E_HOLD;
    end else if (m_mode == M_MEM) begin
      if (m_pend) begin
        exp = E_REDIR; nmode = M_RUN; npend = 1'b0;
      end else begin
        run_rules(lu, branch_taken_i, icache_stall_i, 1'b0, exp, nmode, npend);
      end
    end else if (icache_stall_i) begin
      exp = E_FETCH;
    end else begin
      exp = m_pend ? E_REDIR : E_GO;
      nmode = M_RUN; npend = 1'b0;
    end
  endtask

  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                      input logic [4:0] ert, input logic br, input logic ic, input logic dc,
                      output logic [4:0] got);
    logic [4:0] exp;
    int nmode;
    bit npend;
    @(negedge clk_i);
    id_rs_i = rs; id_rt_i = rt; ex_memread_i = mr; ex_rt_i = ert;
    branch_taken_i = br; icache_stall_i = ic; dcache_stall_i = dc;
    #1;
    model_eval(exp, nmode, npend);
    check("ctrl", {27'd0, obs}, {27'd0, exp});
    check("stall_cnt", {16'd0, stall_cnt_o}, m_stall);
    check("timeout", {31'd0, timeout_o}, {31'd0, m_to});
    got = obs;
    m_mode = nmode;
    m_pend = npend;
    m_wait = (nmode != M_RUN) ? m_wait + 1 : 0;
    if (m_wait >= MAX_WAIT) m_to = 1'b1;
    if (!exp[4] && m_stall < STALL_SAT) m_stall++;
  endtask

  task automatic idle(output logic [4:0] got);
    step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, got);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    check("rst_ctrl", {27'd0, obs}, {27'd0, E_OFF});
    check("rst_stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
    check("rst_timeout", {31'd0, timeout_o}, 32'd0);
    m_mode = M_RUN; m_pend = 1'b0; m_wait = 0; m_stall = 0; m_to = 1'b0;
    repeat (hold) @(negedge clk_i);
    id_rs_i = 5'd1; id_rt_i = 5'd2; ex_memread_i = 1'b0; ex_rt_i = 5'd3;
    branch_taken_i = 1'b0; icache_stall_i = 1'b0; dcache_stall_i = 1'b0;
    rst_n_i = 1'b1;
  endtask

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mr;
    logic [4:0] ert;
    logic       br;
    logic       ic;
    logic       dc;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [4:0] got;

    tbl[0] = '{5'd5, 5'd6, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, E_GO};
    tbl[1] = '{5'd5, 5'd6, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_LU};
    tbl[2] = '{5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, E_LU};
    tbl[3] = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_GO};
    tbl[4] = '{5'd4, 5'd5, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, E_GO};
    tbl[5] = '{5'd4, 5'd5, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, E_REDIR};
    tbl[6] = '{5'd9, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, E_LU};
    tbl[7] = '{5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, E_GO};

    do_reset(3);

    // Single-cycle decisions from RUN
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rs, tbl[i].rt, tbl[i].mr, tbl[i].ert, tbl[i].br, tbl[i].ic, tbl[i].dc, got);
      check($sformatf("tbl%0d", i), {27'd0, got}, {27'd0, tbl[i].exp});
    end

    // Load-use lasts exactly one cycle and counts one stall
    do_reset(1);
    step(5'd5, 5'd6, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, got);
    check("lu_cycle", {27'd0, got}, {27'd0, E_LU});
    idle(got);
    check("lu_after", {27'd0, got}, {27'd0, E_GO});
    check("lu_stall_cnt", {16'd0, stall_cnt_o}, 32'd1);

    // I-cache wait with a branch on its first cycle
    step(5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, got);
    check("ic_c1", {27'd0, got}, {27'd0, E_FETCH});
    step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, got);
    check("ic_c2", {27'd0, got}, {27'd0, E_FETCH});
    step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, got);
    check("ic_c3", {27'd0, got}, {27'd0, E_FETCH});
    idle(got);
    check("ic_exit", {27'd0, got}, {27'd0, E_REDIR});
    idle(got);
    check("ic_after", {27'd0, got}, {27'd0, E_GO});

    // D-cache and I-cache overlap: freeze, then fetch wait
    for (int i = 0; i < 4; i++) begin
      step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, got);
      check($sformatf("both_c%0d", i + 1), {27'd0, got}, {27'd0, E_HOLD});
    end
    for (int i = 0; i < 2; i++) begin
      step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, got);
      check($sformatf("both_fetch%0d", i + 1), {27'd0, got}, {27'd0, E_FETCH});
    end
    idle(got);
    check("both_exit", {27'd0, got}, {27'd0, E_GO});

    // D-cache wait with a branch: redirect issued on exit
    step(5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, got);
    check("dcbr_c1", {27'd0, got}, {27'd0, E_HOLD});
    step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, got);
    check("dcbr_c2", {27'd0, got}, {27'd0, E_HOLD});
    step(5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, got);
    check("dcbr_exit", {27'd0, got}, {27'd0, E_REDIR});
    idle(got);
    check("dcbr_after", {27'd0, got}, {27'd0, E_GO});

    // Long D-cache wait sets the sticky timeout
    do_reset(1);
    for (int i = 1; i <= 70; i++) begin
      step(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, got);
      if (i == 64) check("to_c64", {31'd0, timeout_o}, 32'd0);
      if (i == 65) check("to_c65", {31'd0, timeout_o}, 32'd1);
    end
    idle(got);
    idle(got);
    check("to_sticky", {31'd0, timeout_o}, 32'd1);

    // Reset in the middle of a D-cache wait
    for (int i = 0; i < 3; i++) step(5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, got);
    do_reset(2);
    idle(got);
    check("rst_release", {27'd0, got}, {27'd0, E_GO});

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 6) == 0), got);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
